// File: rtl/map_gen_pkg.sv
// rtl/map_gen_pkg.sv - shared mode encoding and default constants for the map sequencer
package map_gen_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_BOUNCE  = 2'b01,
        MODE_ONESHOT = 2'b10
    } map_mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;
    localparam int DEF_START = 40;
    localparam int DEF_STEP  = 4;
    localparam int DEF_LIMIT = 56;

    // The unused 2'b11 encoding behaves as wrap.
    function automatic map_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_BOUNCE;
            2'b10:   return MODE_ONESHOT;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/map_data_seq_gen_if.sv
// rtl/map_data_seq_gen_if.sv - merged lane/value output stream
interface map_data_seq_gen_if
    import map_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LW    = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    out_lane;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_lane, output out_data, input out_ready);
    modport slave  (input out_valid, input out_lane, input out_data, output out_ready);
endinterface

// File: rtl/map_lane_seq.sv
// rtl/map_lane_seq.sv - one independent wrap/bounce/one-shot value sequencer lane
module map_lane_seq
    import map_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int START = DEF_START,
    parameter int STEP  = DEF_STEP,
    parameter int LIMIT = DEF_LIMIT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             map,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             pick,
    output logic [WIDTH-1:0] value,
    output logic             armed,
    output logic             done,
    output logic             pending,
    output logic             drop
);
    localparam logic [WIDTH:0] START_X = (WIDTH+1)'(START);
    localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] LIMIT_X = (WIDTH+1)'(LIMIT);

    logic           dir_down;
    map_mode_e      lmode;
    logic [WIDTH:0] val_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic           over_top;
    logic           under_bot;
    logic           advance;

    // One extra bit keeps value+STEP from wrapping; the down check is
    // rewritten as value < START+STEP so it can never underflow.
    assign val_x     = {1'b0, value};
    assign up_sum    = val_x + STEP_X;
    assign dn_diff   = val_x - STEP_X;
    assign over_top  = up_sum > LIMIT_X;
    assign under_bot = val_x < (START_X + STEP_X);

    // An advance is any map that produces a new value to emit (arming included);
    // a one-shot lane hitting the top only sets done.
    assign advance = map && !clear && !done &&
                     !(armed && (lmode == MODE_ONESHOT) && over_top);
    assign drop    = advance && pending && !pick;

    // Lane state: clear beats map; a same-cycle pick and advance keeps pending set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value    <= WIDTH'(START);
            dir_down <= 1'b0;
            armed    <= 1'b0;
            done     <= 1'b0;
            pending  <= 1'b0;
            lmode    <= MODE_WRAP;
        end else if (clear) begin
            value    <= WIDTH'(START);
            dir_down <= 1'b0;
            armed    <= 1'b0;
            done     <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (advance) begin
                pending <= 1'b1;
            end else if (pick) begin
                pending <= 1'b0;
            end
            if (map && !done) begin
                if (!armed) begin
                    armed <= 1'b1;
                    lmode <= decode_mode(mode);
                end else begin
                    case (lmode)
                        MODE_BOUNCE: begin
                            if (!dir_down) begin
                                if (over_top) begin
                                    dir_down <= 1'b1;
                                    value    <= dn_diff[WIDTH-1:0];
                                end else begin
                                    value    <= up_sum[WIDTH-1:0];
                                end
                            end else begin
                                if (under_bot) begin
                                    dir_down <= 1'b0;
                                    value    <= up_sum[WIDTH-1:0];
                                end else begin
                                    value    <= dn_diff[WIDTH-1:0];
                                end
                            end
                        end
                        MODE_ONESHOT: begin
                            if (over_top) begin
                                done <= 1'b1;
                            end else begin
                                value <= up_sum[WIDTH-1:0];
                            end
                        end
                        default: begin
                            value <= over_top ? WIDTH'(START) : up_sum[WIDTH-1:0];
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/map_data_seq_gen.sv
// rtl/map_data_seq_gen.sv - multi-lane map sequencer with round-robin merged output
module map_data_seq_gen
    import map_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int START = DEF_START,
    parameter int STEP  = DEF_STEP,
    parameter int LIMIT = DEF_LIMIT,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [LANES-1:0]   map,
    input  logic [LANES-1:0]   clear,
    input  logic [1:0]         mode,
    map_data_seq_gen_if.master stream,
    output logic [LANES-1:0]   lane_en,
    output logic [LANES-1:0]   lane_done,
    output logic [7:0]         drop_cnt
);
    logic [WIDTH-1:0] lane_val [LANES];
    logic [LANES-1:0] lane_pend;
    logic [LANES-1:0] lane_drop;
    logic [LANES-1:0] lane_pick;

    logic             out_valid_r;
    logic [LW-1:0]    out_lane_r;
    logic [WIDTH-1:0] out_data_r;
    logic [LW-1:0]    rr_ptr;

    logic             pick_found;
    logic [LW-1:0]    pick_idx;
    logic [LW-1:0]    next_rr;
    logic             load;
    logic [8:0]       drop_sum;
    logic [9:0]       drop_total;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_pick[gi] = load && (pick_idx == LW'(gi));
            map_lane_seq #(
                .WIDTH (WIDTH),
                .START (START),
                .STEP  (STEP),
                .LIMIT (LIMIT)
            ) u_lane (
                .clk     (clk),
                .resetn  (resetn),
                .map     (map[gi]),
                .clear   (clear[gi]),
                .mode    (mode),
                .pick    (lane_pick[gi]),
                .value   (lane_val[gi]),
                .armed   (lane_en[gi]),
                .done    (lane_done[gi]),
                .pending (lane_pend[gi]),
                .drop    (lane_drop[gi])
            );
        end
    endgenerate

    // Round-robin search: first pending lane at or after rr_ptr.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = (int'(rr_ptr) + k) % LANES;
            if (!pick_found && lane_pend[idx]) begin
                pick_found = 1'b1;
                pick_idx   = LW'(idx);
            end
        end
    end

    assign load    = (!out_valid_r || stream.out_ready) && pick_found;
    assign next_rr = (int'(pick_idx) == LANES - 1) ? '0 : pick_idx + LW'(1);

    // Several lanes may overwrite in the same cycle, so drops are summed.
    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            drop_sum = drop_sum + {8'd0, lane_drop[i]};
        end
        drop_total = {2'b00, drop_cnt} + {1'b0, drop_sum};
    end

    // Output register: holds while stalled, loads the picked lane's current value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            out_lane_r  <= '0;
            out_data_r  <= WIDTH'(START);
            rr_ptr      <= '0;
        end else if (load) begin
            out_valid_r <= 1'b1;
            out_lane_r  <= pick_idx;
            out_data_r  <= lane_val[pick_idx];
            rr_ptr      <= next_rr;
        end else if (stream.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating overwrite counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= 8'd0;
        end else begin
            drop_cnt <= (drop_total > 10'd255) ? 8'd255 : drop_total[7:0];
        end
    end

    assign stream.out_valid = out_valid_r;
    assign stream.out_lane  = out_lane_r;
    assign stream.out_data  = out_data_r;

endmodule

// File: tb/tb_map_data_seq_gen.sv
// tb/tb_map_data_seq_gen.sv - scoreboard bench for map_data_seq_gen
module tb_map_data_seq_gen;
    import map_gen_pkg::*;

    typedef logic [9:0] beat_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] map = '0;
    logic [3:0] clear = '0;
    logic [1:0] mode = '0;
    logic [3:0] lane_en;
    logic [3:0] lane_done;
    logic [7:0] drop_cnt;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_t[$];

    map_data_seq_gen_if #(.WIDTH(8), .LW(2)) sif ();

    map_data_seq_gen dut (
        .clk       (clk),
        .resetn    (resetn),
        .map       (map),
        .clear     (clear),
        .mode      (mode),
        .stream    (sif),
        .lane_en   (lane_en),
        .lane_done (lane_done),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Capture accepted beats away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (resetn && sif.out_valid && sif.out_ready) begin
            got_q.push_back({sif.out_lane, sif.out_data});
            got_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        map = '0;
        clear = '0;
        mode = 2'b00;
        sif.out_ready = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task automatic pulse(input logic [3:0] mask);
        map = mask;
        tick();
        map = '0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", sif.out_valid); end
        n_cmp++; if (sif.out_lane !== 2'd0) begin n_bad++; $display("FAIL rst_lane got %0d exp 0", sif.out_lane); end
        n_cmp++; if (sif.out_data !== 8'd40) begin n_bad++; $display("FAIL rst_data got %0d exp 40", sif.out_data); end
        n_cmp++; if (lane_en !== 4'b0000) begin n_bad++; $display("FAIL rst_lane_en got %b exp 0000", lane_en); end
        n_cmp++; if (lane_done !== 4'b0000) begin n_bad++; $display("FAIL rst_lane_done got %b exp 0000", lane_done); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_wrap();
        int vals[7] = '{40, 44, 48, 52, 56, 40, 44};
        beat_t e, g;
        apply_reset();
        mode = 2'b00;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({2'd0, 8'(vals[i])});
            pulse(4'b0001);
        end
        repeat (4) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wrap_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL wrap_beat got lane %0d data %0d exp lane %0d data %0d", g[9:8], g[7:0], e[9:8], e[7:0]); end
        end
    endtask

    task automatic test_bounce();
        int vals[9] = '{40, 44, 48, 52, 56, 52, 48, 44, 40};
        beat_t e, g;
        apply_reset();
        mode = 2'b01;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({2'd1, 8'(vals[i])});
            pulse(4'b0010);
        end
        repeat (4) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bounce_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL bounce_beat got lane %0d data %0d exp lane %0d data %0d", g[9:8], g[7:0], e[9:8], e[7:0]); end
        end
    endtask

    task automatic test_oneshot();
        beat_t e, g;
        apply_reset();
        mode = 2'b10;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) exp_q.push_back({2'd2, 8'(40 + 4 * i)});
            pulse(4'b0100);
        end
        repeat (4) tick();
        n_cmp++; if (lane_done[2] !== 1'b1) begin n_bad++; $display("FAIL oneshot_done got %b exp 1", lane_done[2]); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL oneshot_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL oneshot_beat got lane %0d data %0d exp lane %0d data %0d", g[9:8], g[7:0], e[9:8], e[7:0]); end
        end
        got_q.delete();
        clear = 4'b0100;
        tick();
        clear = '0;
        n_cmp++; if (lane_done[2] !== 1'b0) begin n_bad++; $display("FAIL oneshot_clr_done got %b exp 0", lane_done[2]); end
        n_cmp++; if (lane_en[2] !== 1'b0) begin n_bad++; $display("FAIL oneshot_clr_en got %b exp 0", lane_en[2]); end
        exp_q.push_back({2'd2, 8'd40});
        pulse(4'b0100);
        repeat (4) tick();
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL oneshot_rearm_count got %0d exp 1", got_q.size()); end
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL oneshot_rearm got lane %0d data %0d exp lane %0d data %0d", g[9:8], g[7:0], e[9:8], e[7:0]); end
    endtask

    task automatic test_backpressure();
        beat_t e, g;
        apply_reset();
        mode = 2'b00;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(4'b1000);
        n_cmp++; if (sif.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b exp 1", sif.out_valid); end
        n_cmp++; if (sif.out_data !== 8'd40) begin n_bad++; $display("FAIL bp_held_data got %0d exp 40", sif.out_data); end
        n_cmp++; if (sif.out_lane !== 2'd3) begin n_bad++; $display("FAIL bp_held_lane got %0d exp 3", sif.out_lane); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL bp_drop got %0d exp 1", drop_cnt); end
        exp_q.push_back({2'd3, 8'd40});
        exp_q.push_back({2'd3, 8'd48});
        sif.out_ready = 1'b1;
        repeat (6) tick();
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL bp_beat got lane %0d data %0d exp lane %0d data %0d", g[9:8], g[7:0], e[9:8], e[7:0]); end
        end
    endtask

    task automatic test_back_to_back();
        beat_t e, g;
        int    t0;
        apply_reset();
        mode = 2'b00;
        for (int r = 0; r < 2; r++) begin
            got_q.delete();
            got_t.delete();
            for (int l = 0; l < 4; l++) exp_q.push_back({2'(l), 8'(40 + 4 * r)});
            pulse(4'b1111);
            repeat (8) tick();
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count r%0d got %0d exp %0d", r, got_q.size(), exp_q.size()); end
            t0 = (got_t.size() > 0) ? got_t[0] : 0;
            for (int l = 0; l < 4; l++) begin
                e = exp_q.pop_front();
                g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
                n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_beat r%0d got lane %0d data %0d exp lane %0d data %0d", r, g[9:8], g[7:0], e[9:8], e[7:0]); end
                if (l < got_t.size()) begin
                    n_cmp++; if (got_t[l] - t0 != l) begin n_bad++; $display("FAIL b2b_spacing r%0d beat %0d got offset %0d exp %0d", r, l, got_t[l] - t0, l); end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        beat_t e, g;
        apply_reset();
        mode = 2'b00;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(4'b0001);
        n_cmp++; if (sif.out_valid !== 1'b1 || drop_cnt !== 8'd1) begin n_bad++; $display("FAIL ar_pre got valid %b drop %0d exp valid 1 drop 1", sif.out_valid, drop_cnt); end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (sif.out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %b exp 0", sif.out_valid); end
        n_cmp++; if (lane_en !== 4'b0000) begin n_bad++; $display("FAIL ar_lane_en got %b exp 0000", lane_en); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL ar_drop got %0d exp 0", drop_cnt); end
        tick();
        resetn = 1'b1;
        sif.out_ready = 1'b1;
        tick();
        got_q.delete();
        exp_q.push_back({2'd0, 8'd40});
        pulse(4'b0001);
        repeat (4) tick();
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL ar_count got %0d exp 1", got_q.size()); end
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
        n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ar_first got lane %0d data %0d exp lane %0d data %0d", g[9:8], g[7:0], e[9:8], e[7:0]); end
    endtask

    initial begin
        sif.out_ready = 1'b1;
        test_reset();
        test_wrap();
        test_bounce();
        test_oneshot();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
